// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Wait-stated data memory slave with byte/halfword/word access.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_OE,
    input  logic        MEM_WS,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    output logic [31:0] RDATA,
    output logic        MEM_RDY,
    output logic        MEM_ERR
);

    localparam int         C_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state, w_next;
    logic [3:0]      r_cnt, w_cnt_next;
    logic [C_AW+1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_size;
    logic            r_signed, r_write, r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept, w_req_err, w_enter_resp;
    logic [C_AW+1:0] w_cur_addr;
    logic [31:0]     w_cur_wdata;
    logic [1:0]      w_cur_size;
    logic            w_cur_signed, w_cur_write, w_cur_err;
    logic [C_AW-1:0] w_idx;
    logic [1:0]      w_off;
    logic [31:0]     w_word, w_shift, w_rd_val, w_wlane;
    logic [15:0]     w_half;
    logic [7:0]      w_byte;
    logic [3:0]      w_be;

    assign w_accept = (r_state == S_IDLE) && (MEM_OE || MEM_WS);

    always_comb begin
        w_req_err = 1'b0;
        if (MEM_OE && MEM_WS) w_req_err = 1'b1;
        case (SIZE)
            2'b01:   if (ADDR[0]) w_req_err = 1'b1;
            2'b10:   if (ADDR[1:0] != 2'b00) w_req_err = 1'b1;
            2'b11:   w_req_err = 1'b1;
            default: ;
        endcase
        if ({2'b00, ADDR[31:2]} >= 32'(DEPTH_WORDS)) w_req_err = 1'b1;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_next = C_WAIT;
                    w_next     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With no wait states RESP is entered at the accept edge itself, so the
    // live inputs stand in for the not-yet-latched transaction.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_cur_addr   = ADDR[C_AW+1:0];
            w_cur_wdata  = WDATA;
            w_cur_size   = SIZE;
            w_cur_signed = SIGNED;
            w_cur_write  = MEM_WS;
            w_cur_err    = w_req_err;
        end else begin
            w_cur_addr   = r_addr;
            w_cur_wdata  = r_wdata;
            w_cur_size   = r_size;
            w_cur_signed = r_signed;
            w_cur_write  = r_write;
            w_cur_err    = r_err;
        end
    end

    assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);
    assign w_idx        = w_cur_addr[C_AW+1:2];
    assign w_off        = w_cur_addr[1:0];
    assign w_word       = r_mem[w_idx];
    assign w_shift      = w_word >> {w_off, 3'b000};
    assign w_byte       = w_shift[7:0];
    assign w_half       = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_rd_val = w_word;
        w_be     = 4'b1111;
        w_wlane  = w_cur_wdata;
        case (w_cur_size)
            2'b00: begin
                w_rd_val = {{24{w_cur_signed & w_byte[7]}}, w_byte};
                w_be     = 4'b0001 << w_off;
                w_wlane  = {4{w_cur_wdata[7:0]}};
            end
            2'b01: begin
                w_rd_val = {{16{w_cur_signed & w_half[15]}}, w_half};
                w_be     = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane  = {2{w_cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            RDATA    <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr   <= ADDR[C_AW+1:0];
                r_wdata  <= WDATA;
                r_size   <= SIZE;
                r_signed <= SIGNED;
                r_write  <= MEM_WS;
                r_err    <= w_req_err;
            end
            if (w_enter_resp && !w_cur_write && !w_cur_err)
                RDATA <= w_rd_val;
        end
    end

    // Storage is never reset; RST gating keeps an aborted write from landing.
    always_ff @(posedge CLK) begin
        if (RST && w_enter_resp && w_cur_write && !w_cur_err) begin
            for (int n = 0; n < 4; n++) begin
                if (w_be[n]) r_mem[w_idx][8*n +: 8] <= w_wlane[8*n +: 8];
            end
        end
    end

    assign MEM_RDY = (r_state == S_RESP);
    assign MEM_ERR = MEM_RDY && r_err;

endmodule
`default_nettype wire
